// File: rtl/alu_system_sequencer.sv
// Hardwired control unit for the ALU system datapath: fetches a 16-bit instruction
// as two bytes into IR, then drives every datapath control input for one EXEC cycle.
module alu_system_sequencer #(
    parameter bit START_AUTO = 1'b0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] IROut,
    output logic        Halted,
    output logic        Illegal,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [1:0]  MuxCSel,
    output logic        MuxDSel,
    output logic [1:0]  DR_FunSel,
    output logic        DR_E,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_L = 3'd1,
        S_FETCH_H = 3'd2,
        S_EXEC    = 3'd3,
        S_HALT    = 3'd4
    } state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_BRA = 4'h1;
    localparam logic [3:0] OP_LDI = 4'h2;
    localparam logic [3:0] OP_ALU = 4'h3;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] RF_FUN_LOAD  = 3'b010;
    localparam logic [1:0] ARF_FUN_INC  = 2'b01;
    localparam logic [1:0] ARF_FUN_LOAD = 2'b10;
    localparam logic [2:0] ARF_SEL_PC   = 3'b100;
    localparam logic [1:0] MUX_IR_LOW   = 2'b11;
    localparam logic [1:0] MUXA_ALU     = 2'b00;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    logic [3:0] opcode;
    logic [1:0] rd_field;
    logic [1:0] rs1_field;
    logic [1:0] rs2_field;
    logic [4:0] fun_field;
    logic       unused_ir_bit;

    assign opcode        = IROut[15:12];
    assign rd_field      = IROut[11:10];
    assign rs1_field     = IROut[9:8];
    assign rs2_field     = IROut[7:6];
    assign fun_field     = IROut[4:0];
    assign unused_ir_bit = IROut[5];

    // RF write enables are ordered bit3=R1 .. bit0=R4, so Rd=0 maps to the MSB.
    function automatic logic [3:0] rd_onehot(input logic [1:0] rd);
        logic [3:0] sel;
        case (rd)
            2'd0:    sel = 4'b1000;
            2'd1:    sel = 4'b0100;
            2'd2:    sel = 4'b0010;
            default: sel = 4'b0001;
        endcase
        return sel;
    endfunction

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (START_AUTO || Start) begin
                    state_d = S_FETCH_L;
                end
            end
            S_FETCH_L: state_d = S_FETCH_H;
            S_FETCH_H: state_d = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_NOP, OP_BRA, OP_LDI, OP_ALU: state_d = S_FETCH_L;
                    OP_HLT:                         state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend only on the registered state and IROut, so an asynchronous
    // reset forces every enable back to its idle value in the same cycle.
    always_comb begin
        Halted      = 1'b0;
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 3'b000;
        RF_RegSel   = 4'b0000;
        RF_ScrSel   = 4'b0000;
        ALU_FunSel  = 5'b00000;
        ALU_WF      = 1'b0;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = 3'b000;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 2'b00;
        MuxDSel     = 1'b0;
        DR_FunSel   = 2'b00;
        DR_E        = 1'b0;
        case (state_q)
            S_FETCH_L, S_FETCH_H: begin
                Mem_CS      = 1'b0;
                ARF_OutDSel = 2'b00;
                IR_Write    = 1'b1;
                IR_LH       = (state_q == S_FETCH_H);
                ARF_RegSel  = ARF_SEL_PC;
                ARF_FunSel  = ARF_FUN_INC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_BRA: begin
                        MuxBSel    = MUX_IR_LOW;
                        ARF_RegSel = ARF_SEL_PC;
                        ARF_FunSel = ARF_FUN_LOAD;
                    end
                    OP_LDI: begin
                        MuxASel   = MUX_IR_LOW;
                        RF_FunSel = RF_FUN_LOAD;
                        RF_RegSel = rd_onehot(rd_field);
                    end
                    OP_ALU: begin
                        RF_OutASel = {1'b0, rs1_field};
                        RF_OutBSel = {1'b0, rs2_field};
                        MuxDSel    = 1'b0;
                        ALU_FunSel = fun_field;
                        ALU_WF     = 1'b1;
                        MuxASel    = MUXA_ALU;
                        RF_FunSel  = RF_FUN_LOAD;
                        RF_RegSel  = rd_onehot(rd_field);
                    end
                    default: ;
                endcase
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

    assign Illegal   = illegal_q;
    assign state_dbg = state_q;

endmodule

// File: doc/alu_system_sequencer.md
Name: alu_system_sequencer

Overview:
- Hardwired control unit for the ALU system datapath (RF, ARF, ALU, Memory, DR, IR, Muxes A-D).
- Fetches each 16-bit instruction as two bytes from memory at PC into IR, then executes it by driving every datapath control input for one cycle.
- Supports NOP, BRA, LDI, ALU reg-reg and HLT. Outputs connect 1:1 to the ALU system control inputs.

Parameters:
START_AUTO, 0, 1 = leave IDLE on the first clock after reset release without waiting for Start

Ports:
Clock  in  1  system clock, all state updates on rising edge
Reset  in  1  asynchronous, active-low; 0 forces IDLE immediately
Start  in  1  one-cycle pulse; IDLE -> FETCH_L
IROut  in  16  instruction register contents (opcode [15:12], Rd [11:10], Rs1 [9:8], Rs2 [7:6], FUN [4:0], IMM [7:0])
Halted  out  1  1 while in HALT
Illegal  out  1  sticky; set on an undefined opcode, cleared only by reset
RF_OutASel  out  3  RF A-port select (000=R1..011=R4)
RF_OutBSel  out  3  RF B-port select
RF_FunSel  out  3  RF function (010=load)
RF_RegSel  out  4  RF write enables, one-hot active-high, bit3=R1..bit0=R4
RF_ScrSel  out  4  scratch enables, always 0
ALU_FunSel  out  5  ALU function
ALU_WF  out  1  ALU flag write
ARF_OutCSel  out  2  always 00
ARF_OutDSel  out  2  memory address source (00=PC)
ARF_FunSel  out  2  ARF function (01=increment, 10=load)
ARF_RegSel  out  3  ARF enables, bit2=PC, bit1=AR, bit0=SP
IR_LH  out  1  0=low byte, 1=high byte
IR_Write  out  1  IR byte load
Mem_WR  out  1  0=read; always 0
Mem_CS  out  1  chip select, active-low
MuxASel  out  2  RF input source (00=ALUOut, 11=IR[7:0])
MuxBSel  out  2  ARF input source (11=IR[7:0])
MuxCSel  out  2  always 00
MuxDSel  out  1  ALU A source (0=OutA)
DR_FunSel  out  2  always 00
DR_E  out  1  always 0

Behaviour:
- States: IDLE, FETCH_L, FETCH_H, EXEC, HALT. Registered state. Outputs are combinational from state and IROut (Moore plus decode).
- Idle default, active in every state unless overridden below: all enables 0 (RF_RegSel, RF_ScrSel, ARF_RegSel, IR_Write, ALU_WF, DR_E), Mem_CS=1, Mem_WR=0, all selects 0. Reset applies this immediately and asynchronously. Illegal=0, Halted=0.
- IDLE: wait for Start=1 (or first edge if START_AUTO=1) -> FETCH_L.
- FETCH_L: Mem_CS=0, ARF_OutDSel=00, IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=01 (PC+1 at edge) -> FETCH_H.
- FETCH_H: same as FETCH_L but IR_LH=1 -> EXEC.
- EXEC decodes IROut[15:12]; one cycle; -> FETCH_L unless stated otherwise.
  - 0x0 NOP: defaults only.
  - 0x1 BRA: MuxBSel=11, ARF_RegSel=100, ARF_FunSel=10; PC <- zero-extended IMM.
  - 0x2 LDI: MuxASel=11, RF_FunSel=010, RF_RegSel=one-hot(Rd); Rd <- {24'b0, IMM}.
  - 0x3 ALU: RF_OutASel={1'b0,Rs1}, RF_OutBSel={1'b0,Rs2}, MuxDSel=0, ALU_FunSel=FUN, ALU_WF=1, MuxASel=00, RF_FunSel=010, RF_RegSel=one-hot(Rd).
  - 0xF HLT: defaults only -> HALT.
  - Other opcodes: defaults only, set Illegal -> HALT.
- HALT: defaults only; Halted=1; Start ignored; exit only by reset.
- Start while not in IDLE is ignored.
- Instruction latency: 3 cycles each (HLT: 3 cycles then HALT).
- PC wraps 0xFFFF -> 0x0000; this is handled by the ARF and needs no special case here.
- Reset during FETCH or EXEC aborts the instruction. Outputs return to defaults within the same cycle. No partial write completes after reset asserts.

Test Plan:
- Reset low mid-EXEC of an ALU op -> RF_RegSel=0000, Mem_CS=1 immediately; state IDLE after release; no Start -> stays IDLE (START_AUTO=0).
- Memory 0x0000:{0x2A,0x24} (LDI R2,0x2A), Start -> FETCH_L/FETCH_H assert IR_Write with LH 0/1 and PC increment; EXEC RF_RegSel=0100, MuxASel=11; R2=0x0000002A, PC=0x0002.
- LDI R1,5; LDI R2,3; ALU R3 <- R1+R2 (FUN=add) -> EXEC drives RF_OutASel=000, RF_OutBSel=001, ALU_WF=1, RF_RegSel=0010; R3=8.
- BRA 0x40 at PC=0x10 -> ARF_RegSel=100, ARF_FunSel=10, MuxBSel=11; next FETCH_L address 0x0040.
- HLT (0xF000) -> Halted=1 from the cycle after EXEC; Start pulses ignored; all enables stay 0 for 20 cycles.
- Opcode 0x7 -> Illegal=1 and Halted=1; Illegal stays 1 until Reset=0.
